// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for the product accumulator: FSM states, the
// window counter width and a sizing helper for the accumulator.
package product_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int COUNT_WIDTH = 8;

  // Smallest accumulator width that holds kernel_size full-scale products without overflow.
  function automatic int min_acc_width(input int bit_width, input int kernel_size);
    logic [63:0] max_prod;
    logic [63:0] max_sum;
    max_prod = ((64'd1 << bit_width) - 64'd1) * ((64'd1 << bit_width) - 64'd1);
    max_sum  = 64'(kernel_size) * max_prod;
    return $clog2(max_sum + 64'd1);
  endfunction

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Combinational accumulator adder. Wraps modulo 2^ACC_WIDTH by default and
// clamps to all-ones when PRODUCT_ACCUMULATOR_SATURATE_EN is defined.
module acc_adder #(
  parameter int ACC_WIDTH = 20
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  output logic                 ovf,
`endif
  output logic [ACC_WIDTH-1:0] sum
);

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  logic [ACC_WIDTH:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[ACC_WIDTH];
    sum  = full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    sum = a + b;
  end
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums KERNEL_SIZE consecutive products into one result and holds it on a
// valid/ready handshake. Optional saturation: PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_WIDTH   = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_prod_valid,
  input  logic [2*BIT_WIDTH-1:0] i_prod_data,
  input  logic                   i_clear,
  output logic                   o_accept,
  output logic [ACC_WIDTH-1:0]   o_sum,
  output logic                   o_sum_valid,
  input  logic                   i_sum_ready,
  output logic [7:0]             o_count,
  output logic                   o_overrun,
  output logic                   o_sat
);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   sum_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   overrun_q;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   take;
  logic                   last;

  assign take = (state_q == ACCUM) && i_prod_valid && !i_clear;
  assign last = (count_q == COUNT_WIDTH'(KERNEL_SIZE - 1));

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  logic add_ovf;
  logic sat_q;

  acc_adder #(.ACC_WIDTH(ACC_WIDTH)) u_adder (
    .a   (acc_q),
    .b   (ACC_WIDTH'(i_prod_data)),
    .ovf (add_ovf),
    .sum (add_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      sat_q <= 1'b0;
    else if (i_clear)
      sat_q <= 1'b0;
    else if (take && add_ovf)
      sat_q <= 1'b1;
  end

  assign o_sat = sat_q;
`else
  acc_adder #(.ACC_WIDTH(ACC_WIDTH)) u_adder (
    .a   (acc_q),
    .b   (ACC_WIDTH'(i_prod_data)),
    .sum (add_sum)
  );

  assign o_sat = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state_q <= ACCUM;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (take && last) state_d = HOLD;
      HOLD:  if (i_sum_ready)  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // A clear only aborts the partial window; a result already in HOLD survives it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q     <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (i_clear)
        overrun_q <= 1'b0;
      else if ((state_q == HOLD) && i_prod_valid)
        overrun_q <= 1'b1;

      if ((state_q == ACCUM) && i_clear) begin
        acc_q   <= '0;
        count_q <= '0;
      end else if (take) begin
        if (last) begin
          sum_q   <= add_sum;
          acc_q   <= '0;
          count_q <= '0;
        end else begin
          acc_q   <= add_sum;
          count_q <= count_q + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_accept    = (state_q == ACCUM);
  assign o_sum_valid = (state_q == HOLD);
  assign o_sum       = sum_q;
  assign o_count     = count_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator: default instance plus
// a 16-bit, 2-product instance for the overflow behaviour.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        prod_valid = 1'b0;
  logic [15:0] prod_data = '0;
  logic        clear = 1'b0;
  logic        sum_ready = 1'b0;
  logic        accept;
  logic [19:0] sum;
  logic        sum_valid;
  logic [7:0]  count;
  logic        overrun;
  logic        sat;

  logic        prod_valid2 = 1'b0;
  logic [15:0] prod_data2 = '0;
  logic        clear2 = 1'b0;
  logic        sum_ready2 = 1'b0;
  logic        accept2;
  logic [15:0] sum2;
  logic        sum_valid2;
  logic [7:0]  count2;
  logic        overrun2;
  logic        sat2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_prod_valid (prod_valid),
    .i_prod_data  (prod_data),
    .i_clear      (clear),
    .o_accept     (accept),
    .o_sum        (sum),
    .o_sum_valid  (sum_valid),
    .i_sum_ready  (sum_ready),
    .o_count      (count),
    .o_overrun    (overrun),
    .o_sat        (sat)
  );

  product_accumulator #(.BIT_WIDTH(8), .KERNEL_SIZE(2), .ACC_WIDTH(16)) dut2 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_prod_valid (prod_valid2),
    .i_prod_data  (prod_data2),
    .i_clear      (clear2),
    .o_accept     (accept2),
    .o_sum        (sum2),
    .o_sum_valid  (sum_valid2),
    .i_sum_ready  (sum_ready2),
    .o_count      (count2),
    .o_overrun    (overrun2),
    .o_sat        (sat2)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic push(input logic [15:0] v);
    prod_valid = 1'b1;
    prod_data  = v;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    prod_data  = '0;
  endtask

  task automatic push2(input logic [15:0] v);
    prod_valid2 = 1'b1;
    prod_data2  = v;
    @(posedge clk); #1;
    prod_valid2 = 1'b0;
    prod_data2  = '0;
  endtask

  task automatic handshake();
    sum_ready = 1'b1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sum !== 20'd0) $display("[TB] FAIL reset_sum: got %0d expected 0", sum); else passes++;
    checks++; if (sum_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", sum_valid); else passes++;
    checks++; if (accept !== 1'b1) $display("[TB] FAIL reset_accept: got %b expected 1", accept); else passes++;
    checks++; if (count !== 8'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else passes++;
    checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else passes++;
    checks++; if (sat !== 1'b0) $display("[TB] FAIL reset_sat: got %b expected 0", sat); else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_window();
    for (int i = 0; i < 8; i++) push(16'd3);
    checks++; if (count !== 8'd8) $display("[TB] FAIL basic_count8: got %0d expected 8", count); else passes++;
    checks++; if (sum_valid !== 1'b0) $display("[TB] FAIL basic_early_valid: got %b expected 0", sum_valid); else passes++;
    push(16'd3);
    checks++; if (sum_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", sum_valid); else passes++;
    checks++; if (sum !== 20'd27) $display("[TB] FAIL basic_sum: got %0d expected 27", sum); else passes++;
    checks++; if (accept !== 1'b0) $display("[TB] FAIL basic_hold_accept: got %b expected 0", accept); else passes++;
    checks++; if (count !== 8'd0) $display("[TB] FAIL basic_count_wrap: got %0d expected 0", count); else passes++;
    handshake();
    checks++; if (accept !== 1'b1) $display("[TB] FAIL basic_accept_after: got %b expected 1", accept); else passes++;
    checks++; if (sum_valid !== 1'b0) $display("[TB] FAIL basic_valid_after: got %b expected 0", sum_valid); else passes++;
  endtask

  task automatic test_max_values();
    for (int i = 0; i < 9; i++) push(16'd65025);
    checks++; if (sum !== 20'd585225) $display("[TB] FAIL max_sum: got %0d expected 585225", sum); else passes++;
    checks++; if (sat !== 1'b0) $display("[TB] FAIL max_sat: got %b expected 0", sat); else passes++;
    handshake();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) push(16'd5);
    sum_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) push(16'd7);
      else begin @(posedge clk); #1; end
    end
    checks++; if (sum !== 20'd45) $display("[TB] FAIL bp_sum_stable: got %0d expected 45", sum); else passes++;
    checks++; if (sum_valid !== 1'b1) $display("[TB] FAIL bp_valid: got %b expected 1", sum_valid); else passes++;
    checks++; if (overrun !== 1'b1) $display("[TB] FAIL bp_overrun: got %b expected 1", overrun); else passes++;
    checks++; if (count !== 8'd0) $display("[TB] FAIL bp_count: got %0d expected 0", count); else passes++;
    handshake();
    for (int i = 0; i < 9; i++) push(16'd1);
    checks++; if (sum !== 20'd9) $display("[TB] FAIL bp_next_sum: got %0d expected 9", sum); else passes++;
    checks++; if (overrun !== 1'b1) $display("[TB] FAIL bp_overrun_sticky: got %b expected 1", overrun); else passes++;
    handshake();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) push(16'd10);
    checks++; if (count !== 8'd4) $display("[TB] FAIL clr_count4: got %0d expected 4", count); else passes++;
    clear = 1'b1;
    push(16'd10);
    clear = 1'b0;
    checks++; if (count !== 8'd0) $display("[TB] FAIL clr_count0: got %0d expected 0", count); else passes++;
    checks++; if (overrun !== 1'b0) $display("[TB] FAIL clr_overrun: got %b expected 0", overrun); else passes++;
    for (int i = 0; i < 9; i++) push(16'd2);
    checks++; if (sum !== 20'd18) $display("[TB] FAIL clr_sum: got %0d expected 18", sum); else passes++;
    checks++; if (overrun !== 1'b0) $display("[TB] FAIL clr_overrun_after: got %b expected 0", overrun); else passes++;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (sum_valid !== 1'b1) $display("[TB] FAIL clr_hold_valid: got %b expected 1", sum_valid); else passes++;
    checks++; if (sum !== 20'd18) $display("[TB] FAIL clr_hold_sum: got %0d expected 18", sum); else passes++;
    handshake();
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 5; i++) push(16'd1);
    checks++; if (count !== 8'd5) $display("[TB] FAIL rmw_count5: got %0d expected 5", count); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 8'd0) $display("[TB] FAIL rmw_async_count: got %0d expected 0", count); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (accept !== 1'b1) $display("[TB] FAIL rmw_accept: got %b expected 1", accept); else passes++;
    checks++; if (sum_valid !== 1'b0) $display("[TB] FAIL rmw_valid: got %b expected 0", sum_valid); else passes++;
    checks++; if (sum !== 20'd0) $display("[TB] FAIL rmw_sum: got %0d expected 0", sum); else passes++;
    for (int i = 0; i < 9; i++) push(16'd4);
    checks++; if (sum !== 20'd36) $display("[TB] FAIL rmw_next_sum: got %0d expected 36", sum); else passes++;
    handshake();
  endtask

  task automatic test_saturation();
    logic [15:0] exp_sum;
    logic        exp_sat;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    exp_sum = 16'd65535;
    exp_sat = 1'b1;
`else
    exp_sum = 16'd64514;
    exp_sat = 1'b0;
`endif
    push2(16'd65025);
    push2(16'd65025);
    checks++; if (sum_valid2 !== 1'b1) $display("[TB] FAIL sat_valid: got %b expected 1", sum_valid2); else passes++;
    checks++; if (sum2 !== exp_sum) $display("[TB] FAIL sat_sum: got %0d expected %0d", sum2, exp_sum); else passes++;
    checks++; if (sat2 !== exp_sat) $display("[TB] FAIL sat_flag: got %b expected %b", sat2, exp_sat); else passes++;
    clear2 = 1'b1;
    @(posedge clk); #1;
    clear2 = 1'b0;
    checks++; if (sat2 !== 1'b0) $display("[TB] FAIL sat_cleared: got %b expected 0", sat2); else passes++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_basic_window();
    test_max_values();
    test_back_to_back();
    test_clear();
    test_reset_mid_window();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
